// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared definitions for the shared-ALU controller, its arbiter and the
// decoder: the R-type opcode, the supported function codes, the controller
// state enum and a small decode helper.
// Ports: none (package).
// Configuration macro (used by alu_rr_arbiter): ALU_SHARE_FIXED_PRIO_EN
package alu_ctrl_pkg;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_MUL = 6'b100110;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } aluStateT;

   // Only a well-formed R-type multiply takes the multi-cycle path; an
   // unsupported opcode/funct always completes in a single cycle.
   function automatic logic isMulOp(input logic [5:0] opcode, input logic [5:0] funct);
      return (opcode == OPC_RTYPE) && (funct == FUNCT_MUL);
   endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter
// Two-way grant logic for the shared ALU. By default it is round-robin:
// on a tie the requester that did not win last time is granted. With
// ALU_SHARE_FIXED_PRIO_EN defined, requester 0 always wins a tie and no
// history is kept.
// Ports:
//   clock, reset     rising-edge clock, async active-high reset
//   enable           grants may only be issued while this is high
//   valid0, valid1   requester valid inputs
//   update           an accept happened this cycle; record the winner
//   grant0, grant1   one-hot (or zero) grant outputs
module alu_rr_arbiter (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic valid0,
   input  logic valid1,
   input  logic update,
   output logic grant0,
   output logic grant1
);

`ifdef ALU_SHARE_FIXED_PRIO_EN
   // Requester 0 has absolute priority; the history inputs are not needed.
   logic unusedInputs;
   assign unusedInputs = ^{clock, reset, update};

   assign grant0 = enable & valid0;
   assign grant1 = enable & valid1 & ~valid0;
`else
   // lastGrant remembers the previous winner; it resets to 1 so that
   // requester 0 wins the first tie after reset.
   logic lastGrant;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lastGrant <= 1'b1;
      end else if (update) begin
         lastGrant <= grant1;
      end
   end

   // A lone requester always wins; on a tie the one that did not win last
   // time is granted.
   assign grant0 = enable & valid0 & (~valid1 | lastGrant);
   assign grant1 = enable & valid1 & (~valid0 | ~lastGrant);
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
// Shares one R-type ALU between two requesters. A 2-way arbiter picks a
// requester, the granted operands are latched, single-cycle ops answer in
// the next cycle and multiply answers MUL_LAT cycles after accept. The
// result is held on a valid/ready response port until it is taken.
// Ports:
//   clock, reset                    rising-edge clock, async active-high reset
//   reqN_valid / reqN_ready         requester N handshake (N = 0, 1)
//   reqN_opcode, reqN_funct         instruction opcode and function code
//   reqN_a, reqN_b                  operands
//   rsp_valid / rsp_ready           response handshake
//   rsp_id, rsp_result, rsp_err     owner, result, unsupported-op flag
// Parameters: DATA_W (operand width), MUL_LAT (multiply latency, 1..15)
// Configuration macro: ALU_SHARE_FIXED_PRIO_EN (fixed priority to port 0)
module alu_share_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [5:0]        req0_opcode,
   input  logic [5:0]        req0_funct,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [5:0]        req1_opcode,
   input  logic [5:0]        req1_funct,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_err
);

   localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

   aluStateT          state, stateNext;
   logic [3:0]        mulCount, mulCountNext;
   logic [DATA_W-1:0] opA, opB;
   logic [5:0]        opCode, opFunct;
   logic              opId;
   logic              grant0, grant1, accept, arbEnable;
   logic [DATA_W-1:0] selA, selB;
   logic [5:0]        selOpcode, selFunct;
   logic [DATA_W-1:0] aluResult;
   logic              aluErr;

   // Grants are only offered while idle, and never while reset is held, so
   // every output reads 0 during reset.
   assign arbEnable = (state == IDLE) && !reset;

   alu_rr_arbiter uArbiter (
      .clock  (clock),
      .reset  (reset),
      .enable (arbEnable),
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .update (accept),
      .grant0 (grant0),
      .grant1 (grant1)
   );

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign accept     = (req0_valid & grant0) | (req1_valid & grant1);

   // Steer the winning requester's fields towards the capture registers.
   assign selA      = grant1 ? req1_a      : req0_a;
   assign selB      = grant1 ? req1_b      : req0_b;
   assign selOpcode = grant1 ? req1_opcode : req0_opcode;
   assign selFunct  = grant1 ? req1_funct  : req0_funct;

   // Capture the granted operation; inputs are ignored at all other times.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         opA     <= '0;
         opB     <= '0;
         opCode  <= '0;
         opFunct <= '0;
         opId    <= 1'b0;
      end else if (accept) begin
         opA     <= selA;
         opB     <= selB;
         opCode  <= selOpcode;
         opFunct <= selFunct;
         opId    <= grant1;
      end
   end

   // Controller state and multiply countdown.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         mulCount <= 4'd0;
      end else begin
         state    <= stateNext;
         mulCount <= mulCountNext;
      end
   end

   // Multiply with MUL_LAT>1 parks in MUL for MUL_LAT-1 cycles; everything
   // else goes straight to RESP. RESP is left on the response handshake.
   always_comb begin
      stateNext    = state;
      mulCountNext = mulCount;
      case (state)
         IDLE: begin
            if (accept) begin
               if (isMulOp(selOpcode, selFunct) && (MUL_LAT > 1)) begin
                  stateNext    = MUL;
                  mulCountNext = MUL_LOAD;
               end else begin
                  stateNext = RESP;
               end
            end
         end
         MUL: begin
            if (mulCount == 4'd1) begin
               stateNext    = RESP;
               mulCountNext = 4'd0;
            end else begin
               mulCountNext = mulCount - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext    = IDLE;
            mulCountNext = 4'd0;
         end
      endcase
   end

   // The ALU works on the latched operands only, so the result cannot move
   // while the response is waiting for the consumer.
   always_comb begin
      aluResult = '0;
      aluErr    = 1'b0;
      if (opCode != OPC_RTYPE) begin
         aluErr = 1'b1;
      end else begin
         case (opFunct)
            FUNCT_ADD: aluResult = opA + opB;
            FUNCT_SUB: aluResult = opA - opB;
            FUNCT_MUL: aluResult = opA * opB;
            FUNCT_AND: aluResult = opA & opB;
            FUNCT_OR:  aluResult = opA | opB;
            default:   aluErr    = 1'b1;
         endcase
      end
   end

   // Response fields are forced to 0 outside RESP so that reset and idle
   // present a clean, all-zero response port.
   assign rsp_valid  = (state == RESP);
   assign rsp_id     = rsp_valid & opId;
   assign rsp_err    = rsp_valid & aluErr;
   assign rsp_result = rsp_valid ? aluResult : '0;

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Shares one R-type ALU datapath between two requesters, e.g. the execute stage (port 0) and the address/branch unit (port 1).
- Arbitrates with 2-way round-robin and captures the granted operands.
- Sequences single-cycle ops and a multi-cycle multiply.
- Returns one tagged result through a valid/ready response port.

Parameters:
- DATA_W, 32, operand/result width.
- MUL_LAT, 4, cycles from accept to rsp_valid for multiply; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- reqN_valid  in  1  requester N (N=0,1) presents an operation.
- reqN_ready  out  1  requester N accepted this cycle.
- reqN_opcode  in  6  instruction opcode.
- reqN_funct  in  6  function code.
- reqN_a  in  DATA_W  operand 1.
- reqN_b  in  DATA_W  operand 2.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  index of the requester that owns the result.
- rsp_result  out  DATA_W  result.
- rsp_err  out  1  unsupported opcode/funct.

Behaviour:
- Reset values: every output is 0. State is IDLE. last_grant=1, so requester 0 wins the first tie. Mul counter is 0.
- States: IDLE, MUL, RESP.
- IDLE:
  - reqN_ready=grant_N, combinational from valid inputs and last_grant.
  - Only one ready is high in a cycle.
  - Accept occurs when reqN_valid && reqN_ready at a clock edge.
  - On accept: latch operands, opcode, funct and id; update last_grant=id.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the one != last_grant.
  - Neither valid: no grant; last_grant unchanged.
- Op decode: opcode must be 6'b000000.
  - funct 100000 ADD: a+b.
  - funct 100010 SUB: a-b, true subtraction.
  - funct 100110 MUL: low DATA_W bits of a*b.
  - funct 100100 AND: a&b.
  - funct 100101 OR: a|b.
  - Anything else: result 0, rsp_err=1, single-cycle.
  - Add/sub wrap modulo 2^DATA_W; no overflow flag.
- Single-cycle op: IDLE->RESP at the accept edge. rsp_valid=1 in the cycle after accept, i.e. latency 1.
- MUL:
  - If MUL_LAT>1: IDLE->MUL, counter loaded with MUL_LAT-1, decremented each cycle.
  - At counter==1: ->RESP, so rsp_valid first high exactly MUL_LAT cycles after accept.
  - If MUL_LAT==1: behaves as single-cycle.
  - The product is computed from the latched operands. It may be registered internally, but the result must be stable when rsp_valid rises.
- RESP:
  - rsp_valid=1; rsp_result/rsp_id/rsp_err held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: ->IDLE; rsp_valid drops the next cycle.
  - Both req*_ready are 0 in MUL and RESP, so there is one outstanding op at most.
  - Minimum initiation interval is 2 cycles: accept, then respond with rsp_ready tied high.
- Requester inputs change or drop while not ready: ignored, with no effect on state.
- Reset asserted mid-MUL or mid-RESP: the operation is discarded with no response; all outputs return to their reset values immediately.

Optional Feature:
- ALU_SHARE_FIXED_PRIO_EN defined: requester 0 always wins when both are valid; last_grant is unused. Requester 1 can starve, which is intended for configurations where execute must never stall.
- Undefined: round-robin as described above.

Decomposition:
- Package alu_ctrl_pkg holds:
  - OPC_RTYPE=6'b000000.
  - FUNCT_ADD/SUB/MUL/AND/OR constants.
  - State enum {IDLE, MUL, RESP}.
- These are shared with the ALU and the decoder.
- Sub-module alu_rr_arbiter holds the 2-way grant logic and the last_grant register with its update enable. This is where the fixed-priority macro applies.

Test Plan:
- Reset, then req0 ADD a=5, b=7 -> req0_ready=1 on the same cycle; next cycle rsp_valid=1, rsp_result=12, rsp_id=0, rsp_err=0.
- Both valid on every cycle after reset, all ops OR 1|2 -> grants alternate 0,1,0,1; each rsp_result=3 with the matching rsp_id.
- req1 MUL a=6, b=9, MUL_LAT=4, rsp_ready=1 -> rsp_valid rises exactly 4 cycles after accept with 54, and both readies stay 0 throughout.
- SUB a=3, b=5 -> 0xFFFFFFFE. Funct 101010 -> result 0, rsp_err=1.
- rsp_ready held low for 5 cycles -> rsp_valid and data remain stable, no new accept occurs; after rsp_ready the next accept comes in the following cycle.
- Reset pulsed mid-MUL (cycle 2) -> rsp_valid never asserts and state is IDLE. With ALU_SHARE_FIXED_PRIO_EN defined and both valid -> requester 0 is granted every time.
